// File: rtl/hdmi_pkg.sv
// Shared constants and helpers for the HDMI data-island audio packet path.
package hdmi_pkg;

    localparam logic [7:0]  ECC_POLY      = 8'b1000_0011;
    localparam int unsigned PACKET_PIXELS = 32;
    localparam int unsigned HEADER_BITS   = 24;
    localparam int unsigned SUB_BITS      = 56;
    localparam int unsigned PARITY_BITS   = 8;
    localparam int unsigned SUB_COUNT     = 4;
    localparam int unsigned COUNTER_W     = $clog2(PACKET_PIXELS);

    typedef enum logic [7:0] {
        PKT_ACR             = 8'h01,
        PKT_AUDIO_SAMPLE    = 8'h02,
        PKT_AUDIO_INFOFRAME = 8'h84
    } packet_type_e;

    // One bit of the reflected BCH LFSR.
    function automatic logic [PARITY_BITS-1:0] ecc_step(
        input logic [PARITY_BITS-1:0] ecc,
        input logic                   d,
        input logic [PARITY_BITS-1:0] poly
    );
        return (ecc >> 1) ^ ((ecc[0] ^ d) ? poly : '0);
    endfunction

endpackage

// File: rtl/audio_packet_serializer_if.sv
// Packet bus between the audio packet generators and the serializer.
interface audio_packet_serializer_if;
    import hdmi_pkg::*;

    logic                   data_island_period;
    logic [HEADER_BITS-1:0] header;
    logic [SUB_BITS-1:0]    sub [SUB_COUNT-1:0];
    logic                   packet_enable;
    logic [8:0]             packet_data;
    logic                   packet_valid;

    modport master (
        output data_island_period, header, sub,
        input  packet_enable, packet_data, packet_valid
    );

    modport slave (
        input  data_island_period, header, sub,
        output packet_enable, packet_data, packet_valid
    );

endinterface

// File: rtl/bch_ecc_lfsr.sv
// BCH parity LFSR consuming STEPS data bits per enabled cycle, bit 0 first.
module bch_ecc_lfsr
    import hdmi_pkg::*;
#(
    parameter int unsigned STEPS = 1,
    parameter logic [7:0]  POLY  = hdmi_pkg::ECC_POLY
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [STEPS-1:0]       data,
    output logic [PARITY_BITS-1:0] ecc
);

    logic [PARITY_BITS-1:0] ecc_next;

    // clear with enable steps from zero, so the first bit of a packet ignores stale parity
    always_comb begin
        ecc_next = clear ? '0 : ecc;
        if (enable) begin
            for (int unsigned i = 0; i < STEPS; i++) begin
                ecc_next = ecc_step(ecc_next, data[i], POLY);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            ecc <= '0;
        end else begin
            ecc <= ecc_next;
        end
    end

endmodule

// File: rtl/audio_packet_serializer.sv
// Serializes header + four subpackets with BCH parity into 32 data-island pixels of 9 bits.
module audio_packet_serializer
    import hdmi_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = hdmi_pkg::ECC_POLY
) (
    input  logic               clk_pixel,
    input  logic               reset,
    audio_packet_serializer_if.slave bus
);

    logic [COUNTER_W-1:0]   counter;
    logic [HEADER_BITS-1:0] hdr_sh;
    logic [SUB_BITS-1:0]    sub_sh [SUB_COUNT];
    logic                   first;
    logic                   ecc_clear;
    logic                   hdr_en;
    logic                   sub_en;
    logic                   hdr_bit;
    logic [1:0]             sub_bits [SUB_COUNT];
    logic [PARITY_BITS-1:0] hdr_ecc;
    logic [PARITY_BITS-1:0] sub_ecc [SUB_COUNT];
    logic [8:0]             word;
    logic [8:0]             data_q;
    logic                   valid_q;

    assign first     = (counter == '0);
    assign ecc_clear = !bus.data_island_period || first;
    assign hdr_en    = bus.data_island_period && (counter < COUNTER_W'(HEADER_BITS));
    assign sub_en    = bus.data_island_period && (counter < COUNTER_W'(SUB_BITS / 2));

    assign bus.packet_enable = !reset && bus.data_island_period && first;
    assign bus.packet_data   = data_q;
    assign bus.packet_valid  = valid_q;

    // Index 0 bypasses the shadow registers; they only load on that same edge.
    always_comb begin
        hdr_bit = first ? bus.header[0] : hdr_sh[counter];
        for (int unsigned k = 0; k < SUB_COUNT; k++) begin
            sub_bits[k] = first ? bus.sub[k][1:0]
                                : {sub_sh[k][{counter, 1'b1}], sub_sh[k][{counter, 1'b0}]};
        end
    end

    bch_ecc_lfsr #(.STEPS(1), .POLY(ECC_POLY)) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (ecc_clear),
        .enable    (hdr_en),
        .data      (hdr_bit),
        .ecc       (hdr_ecc)
    );

    for (genvar k = 0; k < SUB_COUNT; k++) begin : g_sub_ecc
        bch_ecc_lfsr #(.STEPS(2), .POLY(ECC_POLY)) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .clear     (ecc_clear),
            .enable    (sub_en),
            .data      (sub_bits[k]),
            .ecc       (sub_ecc[k])
        );
    end

    always_comb begin
        word    = '0;
        word[0] = hdr_en ? hdr_bit : hdr_ecc[counter[2:0]];
        for (int unsigned k = 0; k < SUB_COUNT; k++) begin
            if (sub_en) begin
                word[1 + k] = sub_bits[k][0];
                word[5 + k] = sub_bits[k][1];
            end else begin
                word[1 + k] = sub_ecc[k][{counter[1:0], 1'b0}];
                word[5 + k] = sub_ecc[k][{counter[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter <= '0;
            hdr_sh  <= '0;
            for (int unsigned k = 0; k < SUB_COUNT; k++) begin
                sub_sh[k] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.data_island_period;
            data_q  <= bus.data_island_period ? word : '0;
            counter <= bus.data_island_period ? counter + 1'b1 : '0;
            if (bus.data_island_period && first) begin
                hdr_sh <= bus.header;
                for (int unsigned k = 0; k < SUB_COUNT; k++) begin
                    sub_sh[k] <= bus.sub[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_packet_serializer.sv
// Randomized bench for audio_packet_serializer against a codeword-level reference model.
module tb_audio_packet_serializer;
    import hdmi_pkg::*;

    logic clk_pixel = 1'b0;
    logic reset;

    always #5 clk_pixel = ~clk_pixel;

    audio_packet_serializer_if bus ();

    audio_packet_serializer #(.ECC_POLY(8'h83)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned m_cnt  = 0;
    logic [8:0]  m_words [32];
    logic [8:0]  exp_data;
    logic        exp_valid;
    logic [31:0] hdr_cap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Parity of the first nbits of v, fed LSB first through g(x)=1+x^6+x^7+x^8 (reflected).
    function automatic logic [7:0] ref_bch(input logic [55:0] v, input int unsigned nbits);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int unsigned i = 0; i < nbits; i++) begin
            fb = e[0] ^ v[i];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Build the whole 32-pixel packet from the full codewords {parity, data}.
    task automatic build_packet();
        logic [31:0] hcw;
        logic [63:0] scw [4];
        hcw = {ref_bch({32'h0, bus.header}, 24), bus.header};
        for (int k = 0; k < 4; k++) scw[k] = {ref_bch(bus.sub[k], 56), bus.sub[k]};
        for (int n = 0; n < 32; n++) begin
            m_words[n][0] = hcw[n];
            for (int k = 0; k < 4; k++) begin
                m_words[n][1 + k] = scw[k][2 * n];
                m_words[n][5 + k] = scw[k][2 * n + 1];
            end
        end
    endtask

    task automatic cycle(input logic r, input logic d, input string tag);
        logic exp_en;
        @(negedge clk_pixel);
        reset = r;
        bus.data_island_period = d;
        #1;
        exp_en = !r && d && (m_cnt == 0);
        check_eq({tag, ":enable"}, {31'h0, bus.packet_enable}, {31'h0, exp_en});
        if (r || !d) begin
            exp_data  = '0;
            exp_valid = 1'b0;
            m_cnt     = 0;
        end else begin
            if (m_cnt == 0) build_packet();
            exp_data  = m_words[m_cnt];
            exp_valid = 1'b1;
            m_cnt     = (m_cnt + 1) % 32;
        end
        @(posedge clk_pixel);
        #1;
        check_eq({tag, ":valid"}, {31'h0, bus.packet_valid}, {31'h0, exp_valid});
        check_eq({tag, ":data"}, {23'h0, bus.packet_data}, {23'h0, exp_data});
        hdr_cap = {bus.packet_data[0], hdr_cap[31:1]};
    endtask

    task automatic set_inputs(input logic [23:0] h, input logic rnd);
        bus.header = rnd ? 24'($urandom) : h;
        for (int k = 0; k < 4; k++) bus.sub[k] = rnd ? 56'({$urandom, $urandom}) : 56'h0;
    endtask

    initial begin
        reset = 1'b1;
        bus.data_island_period = 1'b0;
        set_inputs(24'h0, 1'b0);
        hdr_cap = '0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "reset");
        cycle(1'b0, 1'b0, "idle");

        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, "zero");
        cycle(1'b0, 1'b0, "zero_end");

        set_inputs({16'h0, PKT_ACR}, 1'b0);
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, "acr");
        check_eq("acr_hdr_codeword", hdr_cap, {8'h4A, 24'h000001});
        cycle(1'b0, 1'b0, "acr_end");

        // Inputs change every cycle, including right after packet_enable.
        for (int i = 0; i < 100 * 32; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b1, "rand");
        end

        for (int i = 0; i < 13; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b1, "pre_abort");
        end
        for (int i = 0; i < 5; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b0, "abort");
        end
        for (int i = 0; i < 32; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b1, "post_abort");
        end

        for (int i = 0; i < 20; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b1, "pre_reset");
        end
        set_inputs(24'h0, 1'b1);
        cycle(1'b1, 1'b1, "mid_reset");
        for (int i = 0; i < 32; i++) begin
            set_inputs(24'h0, 1'b1);
            cycle(1'b0, 1'b1, "post_reset");
        end
        cycle(1'b0, 1'b0, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
